// File: rtl/spectrum_bank_ctrl_pkg.sv
// Shared definitions for the ping-pong spectrum bin buffer: state encoding and
// default geometry, shared with graph_renderer.
package spectrum_bank_ctrl_pkg;

  localparam int DATA_BITS_DEF = 9;
  localparam int NUM_BINS_DEF  = 256;
  localparam int ADDR_BITS_DEF = 8;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_FULL = 2'd1,
    ST_SWAP = 2'd2
  } bank_state_t;

  // Width of the in-bank bin index; at least one bit so the RAM address is legal.
  function automatic int bin_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spectrum_bank_ram.sv
// Simple dual-port bin memory holding both banks: one write port, one
// registered read port. Contents are deliberately not reset.
module spectrum_bank_ram #(
  parameter int DATA_BITS = 9,
  parameter int ABITS     = 9
) (
  input  logic                 clk_pixel,
  input  logic                 we,
  input  logic [ABITS-1:0]     waddr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [ABITS-1:0]     raddr,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [2**ABITS];

  always_ff @(posedge clk_pixel) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/spectrum_bank_ctrl.sv
// Ping-pong bin-buffer controller: producer fills the back bank, renderer reads
// the front bank, and the banks swap only on a frame_start after a full frame.
module spectrum_bank_ctrl
  import spectrum_bank_ctrl_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int NUM_BINS  = NUM_BINS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic                 clk_pixel,
  input  logic                 rst_n,
  // Producer handshake: a sample transfers on a rising edge where wr_valid and
  // wr_ready are both high; the producer holds addr/data/last until then.
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_last,
  input  logic                 frame_start,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 disp_bank,
  output logic                 frame_ready,
  output logic [7:0]           stale_count,
  output bank_state_t          dbg_state
);

  localparam int BIN_BITS  = bin_bits(NUM_BINS);
  localparam int RAM_ABITS = BIN_BITS + 1;
  localparam logic [ADDR_BITS:0] BIN_LIMIT = (ADDR_BITS + 1)'(NUM_BINS);

  bank_state_t          state_q, state_d;
  logic                 armed_q;
  logic                 disp_bank_q;
  logic                 have_frame_q;
  logic                 rd_ok_q;
  logic [7:0]           stale_q;
  logic                 accept;
  logic                 wr_en;
  logic [RAM_ABITS-1:0] ram_waddr;
  logic [RAM_ABITS-1:0] ram_raddr;
  logic [DATA_BITS-1:0] ram_rdata;

  // armed_q holds wr_ready low for the first cycle after reset release.
  assign wr_ready  = armed_q && (state_q == ST_FILL);
  assign accept    = wr_valid && wr_ready;
  assign wr_en     = accept && ({1'b0, wr_addr} < BIN_LIMIT);
  assign ram_waddr = {~disp_bank_q, wr_addr[BIN_BITS-1:0]};
  assign ram_raddr = {disp_bank_q, rd_addr[BIN_BITS-1:0]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: if (accept && wr_last) state_d = ST_FULL;
      ST_FULL: if (frame_start) state_d = ST_SWAP;
      ST_SWAP: state_d = ST_FILL;
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FILL;
      armed_q      <= 1'b0;
      disp_bank_q  <= 1'b0;
      have_frame_q <= 1'b0;
      stale_q      <= 8'd0;
      rd_ok_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (state_q == ST_SWAP) begin
        disp_bank_q  <= ~disp_bank_q;
        have_frame_q <= 1'b1;
      end
      // Any frame_start outside FULL leaves the display showing an old spectrum.
      if (frame_start && (state_q != ST_FULL) && (stale_q != 8'hFF)) begin
        stale_q <= stale_q + 8'd1;
      end
      rd_ok_q <= have_frame_q && ({1'b0, rd_addr} < BIN_LIMIT);
    end
  end

  spectrum_bank_ram #(
    .DATA_BITS (DATA_BITS),
    .ABITS     (RAM_ABITS)
  ) u_ram (
    .clk_pixel (clk_pixel),
    .we        (wr_en),
    .waddr     (ram_waddr),
    .wdata     (wr_data),
    .raddr     (ram_raddr),
    .rdata     (ram_rdata)
  );

  assign rd_data     = rd_ok_q ? ram_rdata : '0;
  assign disp_bank   = disp_bank_q;
  assign frame_ready = (state_q == ST_FULL);
  assign stale_count = stale_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_spectrum_bank_ctrl.sv
// Directed bench for spectrum_bank_ctrl with 9-bit bin addresses so that
// out-of-range bins can be driven.
module tb_spectrum_bank_ctrl;
  import spectrum_bank_ctrl_pkg::*;

  localparam int DW = 9;
  localparam int AW = 9;

  logic          clk_pixel = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic          frame_start;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          disp_bank;
  logic          frame_ready;
  logic [7:0]    stale_count;
  bank_state_t   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  spectrum_bank_ctrl #(
    .DATA_BITS (DW),
    .NUM_BINS  (256),
    .ADDR_BITS (AW)
  ) dut (
    .clk_pixel   (clk_pixel),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .frame_start (frame_start),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .disp_bank   (disp_bank),
    .frame_ready (frame_ready),
    .stale_count (stale_count),
    .dbg_state   (dbg_state)
  );

  // Clock / watchdog
  always #5 clk_pixel = ~clk_pixel;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one sample and hold it until the controller takes it (bounded wait).
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic last, input logic fs);
    logic done;
    done        = 1'b0;
    wr_valid    = 1'b1;
    wr_addr     = a;
    wr_data     = d;
    wr_last     = last;
    frame_start = fs;
    for (int i = 0; i < 20 && !done; i++) begin
      if (wr_ready) done = 1'b1;
      tick();
    end
    wr_valid    = 1'b0;
    wr_last     = 1'b0;
    frame_start = 1'b0;
    check("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd_addr = a;
    tick();
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    logic saw_ready;
    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    wr_last = 1'b0; frame_start = 1'b0; rd_addr = '0;

    // 1: reset state
    tick(); tick();
    check("rst_wr_ready",    32'(wr_ready), 32'd0);
    check("rst_rd_data",     32'(rd_data), 32'd0);
    check("rst_disp_bank",   32'(disp_bank), 32'd0);
    check("rst_frame_ready", 32'(frame_ready), 32'd0);
    check("rst_stale",       32'(stale_count), 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(wr_ready), 32'd0);
    tick();
    check("ready_after_edge", 32'(wr_ready), 32'd1);
    read_check("rd_no_frame", 9'd5, 9'd0);

    // 2: full frame into bank 1, then swap
    for (int b = 0; b < 256; b++) send(9'(b), 9'(b), (b == 255), 1'b0);
    check("t2_state_full", 32'(dbg_state), 32'd1);
    check("t2_wr_ready",   32'(wr_ready), 32'd0);
    check("t2_frame_rdy",  32'(frame_ready), 32'd1);
    pulse_frame_start();
    check("t2_state_swap", 32'(dbg_state), 32'd2);
    check("t2_swap_ready", 32'(wr_ready), 32'd0);
    check("t2_bank_old",   32'(disp_bank), 32'd0);
    tick();
    check("t2_disp_bank",  32'(disp_bank), 32'd1);
    check("t2_fr_clear",   32'(frame_ready), 32'd0);
    check("t2_stale",      32'(stale_count), 32'd0);
    read_check("t2_rd100", 9'd100, 9'd100);
    read_check("t2_rd255", 9'd255, 9'd255);
    read_check("t2_rd300", 9'd300, 9'd0);

    // 3: back-pressure while a full bank waits
    for (int b = 0; b < 256; b++) send(9'(b), 9'(511 - b), (b == 255), 1'b0);
    wr_valid = 1'b1; wr_addr = 9'd7; wr_data = 9'd0; rd_addr = 9'd7;
    saw_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (wr_ready) saw_ready = 1'b1;
    end
    check("t3_no_ready",   32'(saw_ready), 32'd0);
    check("t3_front_old",  32'(rd_data), 32'd7);
    pulse_frame_start();
    check("t3_swap_ready", 32'(wr_ready), 32'd0);
    tick();
    check("t3_ready_2cyc", 32'(wr_ready), 32'd1);
    wr_valid = 1'b0;
    check("t3_disp_bank",  32'(disp_bank), 32'd0);
    tick();
    check("t3_rd7_new",    32'(rd_data), 32'd504);

    // 4: frame_start with no completed frame is stale
    for (int i = 0; i < 3; i++) begin
      pulse_frame_start();
      tick();
    end
    check("t4_stale",     32'(stale_count), 32'd3);
    check("t4_disp_bank", 32'(disp_bank), 32'd0);
    check("t4_state",     32'(dbg_state), 32'd0);

    // 5: wr_last coincident with frame_start defers the swap
    for (int b = 0; b < 9; b++) send(9'(b), 9'(b + 20), 1'b0, 1'b0);
    send(9'd9, 9'd29, 1'b1, 1'b1);
    check("t5_state_full", 32'(dbg_state), 32'd1);
    check("t5_stale",      32'(stale_count), 32'd4);
    tick(); tick();
    check("t5_no_swap",    32'(disp_bank), 32'd0);
    pulse_frame_start();
    check("t5_stale_hold", 32'(stale_count), 32'd4);
    tick();
    check("t5_disp_bank",  32'(disp_bank), 32'd1);
    read_check("t5_rd9",   9'd9, 9'd29);
    read_check("t5_rd100_kept", 9'd100, 9'd100);

    // 6: out-of-range write suppressed, then asynchronous mid-fill reset
    send(9'd300, 9'd5, 1'b0, 1'b0);
    check("t6_still_fill", 32'(dbg_state), 32'd0);
    send(9'd256, 9'd7, 1'b1, 1'b0);
    check("t6_full",       32'(dbg_state), 32'd1);
    pulse_frame_start();
    tick();
    check("t6_disp_bank",  32'(disp_bank), 32'd0);
    read_check("t6_rd44",  9'd44, 9'd467);
    read_check("t6_rd0",   9'd0, 9'd511);
    read_check("t6_rd256", 9'd256, 9'd0);
    send(9'd0, 9'd1, 1'b0, 1'b0);
    send(9'd1, 9'd2, 1'b0, 1'b0);
    read_check("t6_rd0_pre", 9'd0, 9'd511);
    check("t6_stale_pre", 32'(stale_count), 32'd4);
    wr_valid = 1'b1; wr_addr = 9'd2; wr_data = 9'd3;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_ready", 32'(wr_ready), 32'd0);
    check("t6_async_rd",    32'(rd_data), 32'd0);
    check("t6_async_stale", 32'(stale_count), 32'd0);
    check("t6_async_state", 32'(dbg_state), 32'd0);
    check("t6_async_fr",    32'(frame_ready), 32'd0);
    check("t6_async_bank",  32'(disp_bank), 32'd0);
    wr_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    read_check("t6_rd_after_rst", 9'd0, 9'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spectrum_bank_ctrl.md
Name: spectrum_bank_ctrl

Overview:
Ping-pong bin-buffer controller between the FFT magnitude producer and the graph renderer's synchronous data read port.
- Owns a two-bank bin memory. The producer fills the back bank; the renderer reads the front bank.
- Banks swap only at a frame boundary, so a displayed frame never mixes two spectra.
- Applies back-pressure to the producer while a completed back bank waits for its swap.
- Runs entirely in the clk_pixel domain; the producer side is already synchronised to clk_pixel.

Parameters:
DATA_BITS, 9, magnitude width; matches the renderer data_value width.
NUM_BINS, 256, bins per bank; must be at most 256.
ADDR_BITS, 8, bin address width.

Ports:
clk_pixel  in  1  pixel clock; all logic rising-edge.
rst_n  in  1  asynchronous, active-low reset.
wr_valid  in  1  producer presents a bin sample.
wr_ready  out  1  controller accepts the sample this cycle.
wr_addr  in  ADDR_BITS  bin index of the sample.
wr_data  in  DATA_BITS  bin magnitude.
wr_last  in  1  marks the final sample of a spectrum frame.
frame_start  in  1  one-cycle pulse at start of vertical blanking.
rd_addr  in  ADDR_BITS  renderer read address.
rd_data  out  DATA_BITS  front-bank value, registered.
disp_bank  out  1  index of the current front bank.
frame_ready  out  1  back bank complete and awaiting swap.
stale_count  out  8  saturating count of frame_start pulses with no new frame.

Behaviour:
- Reset (asynchronous):
  - state = FILL, disp_bank = 0, back bank = 1.
  - wr_ready = 0 while rst_n is low; it rises 1 cycle after reset deasserts.
  - rd_data = 0, frame_ready = 0, stale_count = 0, have_frame = 0.
  - RAM contents are not reset.
- Handshake: a sample is accepted when wr_valid and wr_ready are both high at a clock edge. The producer holds its data stable until accepted.
- Write addressing:
  - An accepted sample writes RAM address {~disp_bank, wr_addr[ADDR_BITS-1:0]}.
  - If wr_addr >= NUM_BINS, the sample is accepted but the write is suppressed.
- State FILL (wr_ready = 1): an accepted sample with wr_last = 1 moves the state to FULL.
- State FULL (wr_ready = 0, frame_ready = 1): on frame_start the state moves to SWAP.
- State SWAP (wr_ready = 0), lasting exactly 1 cycle:
  - disp_bank toggles and have_frame is set to 1.
  - The state returns to FILL, so wr_ready is 1 on the following cycle.
- Same-cycle wr_last and frame_start: the transition to FULL takes effect at that edge, and the frame_start is not consumed for a swap. The swap waits for the next frame_start. That frame_start counts as stale.
- stale_count increments (saturating at 255) on every frame_start that does not cause a swap, i.e. whenever the state is FILL or SWAP when frame_start is sampled.
- Read path, 1-cycle latency:
  - rd_data at edge n+1 equals RAM[{disp_bank, rd_addr}] sampled at edge n.
  - rd_data is forced to 0 when have_frame = 0 or rd_addr >= NUM_BINS.
- Bank change seen by the renderer: the disp_bank toggle is visible to reads issued from the cycle after SWAP. A read issued in the SWAP cycle still returns old-bank data.
- Read/write isolation: reads and writes never target the same bank, so there is no read-during-write hazard. A write in the SWAP cycle is impossible because wr_ready = 0.
- Mid-frame reset: returns to the reset state immediately. A partially filled back bank is discarded logically, because have_frame = 0 forces rd_data = 0.
- Incomplete frames: a frame of fewer than NUM_BINS samples is legal. Unwritten bins keep their previous bank contents.

Decomposition:
- Shared package/header holds:
  - state encoding FILL = 2'd0, FULL = 2'd1, SWAP = 2'd2;
  - NUM_BINS / ADDR_BITS defaults, shared with graph_renderer.
- One sub-module, spectrum_bank_ram:
  - simple dual-port synchronous RAM, depth 2*NUM_BINS, width DATA_BITS;
  - one write port and one registered read port, inferred as block RAM.
- The controller holds the FSM, bank bit, stale counter and the read-data masking.

Test Plan:
1. Reset, then read rd_addr = 5 → rd_data = 0, disp_bank = 0, wr_ready = 1 one cycle after rst_n rises.
2. Write bins 0..255 with wr_data = bin and wr_last on bin 255, then pulse frame_start → state FULL, wr_ready = 0, frame_ready = 1; after the swap disp_bank = 1 and reading addr 100 returns 100 one cycle later.
3. Complete a frame, then hold wr_valid = 1 with no frame_start for 50 cycles → no sample accepted, wr_ready stays 0; after frame_start, wr_ready = 1 two cycles later.
4. Three frame_start pulses with no completed frame → stale_count = 3, disp_bank unchanged.
5. wr_last accepted in the same cycle as frame_start → no swap that frame, stale_count increments by 1; the next frame_start swaps.
6. Write of addr 300 with NUM_BINS = 256 and ADDR_BITS = 9 → accepted, no RAM change; assert rst_n low mid-fill → all outputs return to reset values asynchronously.
